// File: rtl/hazard_scoreboard_ctrl.sv
// Pipeline hazard controller: load-use bubble insertion, branch flush, memory-wait freeze,
// plus saturating performance counters for stall cycles and flush events.
module hazard_scoreboard_ctrl #(
    parameter int IDX_W     = 5,
    parameter int LU_CYCLES = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] fd_rs1_index,
    input  logic [IDX_W-1:0] fd_rs2_index,
    input  logic             fd_rs1_used,
    input  logic             fd_rs2_used,
    input  logic [IDX_W-1:0] de_rd_index,
    input  logic             de_wb_en,
    input  logic             de_is_load,
    input  logic             em_branch_taken,
    input  logic             mem_req_valid,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             pc_stall,
    output logic             fd_stall,
    output logic             de_stall,
    output logic             em_stall,
    output logic             mw_stall,
    output logic             fd_flush,
    output logic             de_flush,
    output logic             em_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        LU_STALL = 1'b1
    } state_t;

    localparam logic [2:0] BCNT_RELOAD = 3'(LU_CYCLES - 1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [2:0] bcnt_r;
    logic [2:0] bcnt_nxt_s;
    logic       lu_hit_s;
    logic       mem_wait_s;
    logic       flush_evt_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (val == {CNT_W{1'b1}}) begin
            sat_inc = val;
        end else begin
            sat_inc = val + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Hazard detection; only loads can hazard since ALU results are forwarded.
    always_comb begin
        lu_hit_s   = de_is_load & de_wb_en & (de_rd_index != {IDX_W{1'b0}}) &
                     ((fd_rs1_used & (fd_rs1_index == de_rd_index)) |
                      (fd_rs2_used & (fd_rs2_index == de_rd_index)));
        mem_wait_s = mem_req_valid & ~mem_ready;
    end

    // Next-state and stage-control decode; freeze outranks flush, flush outranks bubbles.
    always_comb begin
        state_nxt_s = state_r;
        bcnt_nxt_s  = bcnt_r;
        pc_stall    = 1'b0;
        fd_stall    = 1'b0;
        de_stall    = 1'b0;
        em_stall    = 1'b0;
        mw_stall    = 1'b0;
        fd_flush    = 1'b0;
        de_flush    = 1'b0;
        em_flush    = 1'b0;
        flush_evt_s = 1'b0;
        if (mem_wait_s) begin
            pc_stall = 1'b1;
            fd_stall = 1'b1;
            de_stall = 1'b1;
            em_stall = 1'b1;
            mw_stall = 1'b1;
        end else if (em_branch_taken) begin
            fd_flush    = 1'b1;
            de_flush    = 1'b1;
            em_flush    = 1'b1;
            flush_evt_s = 1'b1;
            state_nxt_s = IDLE;
            bcnt_nxt_s  = 3'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (lu_hit_s) begin
                        pc_stall = 1'b1;
                        fd_stall = 1'b1;
                        de_flush = 1'b1;
                        if (LU_CYCLES > 1) begin
                            state_nxt_s = LU_STALL;
                            bcnt_nxt_s  = BCNT_RELOAD;
                        end else begin
                            state_nxt_s = IDLE;
                            bcnt_nxt_s  = 3'd0;
                        end
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                LU_STALL: begin
                    // lu_hit is deliberately ignored here: the bubble run is not retriggered.
                    pc_stall = 1'b1;
                    fd_stall = 1'b1;
                    de_flush = 1'b1;
                    if (bcnt_r <= 3'd1) begin
                        state_nxt_s = IDLE;
                        bcnt_nxt_s  = 3'd0;
                    end else begin
                        bcnt_nxt_s  = bcnt_r - 3'd1;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    bcnt_nxt_s  = 3'd0;
                end
            endcase
        end
    end

    // FSM state and bubble counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            bcnt_r  <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            bcnt_r  <= bcnt_nxt_s;
        end
    end

    // Saturating perf counters; clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            stall_cycles <= {CNT_W{1'b0}};
            flush_events <= {CNT_W{1'b0}};
        end else begin
            if (pc_stall) begin
                stall_cycles <= sat_inc(stall_cycles);
            end else begin
                stall_cycles <= stall_cycles;
            end
            if (flush_evt_s) begin
                flush_events <= sat_inc(flush_events);
            end else begin
                flush_events <= flush_events;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Directed bench for hazard_scoreboard_ctrl: three instances (LU_CYCLES=1, LU_CYCLES=3, CNT_W=2)
// share stimulus; each scenario task checks the instance it targets.
module tb_hazard_scoreboard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] fd_rs1_index, fd_rs2_index, de_rd_index;
    logic       fd_rs1_used, fd_rs2_used, de_wb_en, de_is_load;
    logic       em_branch_taken, mem_req_valid, mem_ready, cnt_clr;

    logic [7:0]  outs1, outs3, outss;
    logic [15:0] sc1, fe1, sc3, fe3;
    logic [1:0]  scs, fes;

    int checks   = 0;
    int failures = 0;

    // {pc, fd, de, em, mw stall, fd, de, em flush}
    localparam logic [7:0] O_NONE   = 8'b0000_0000;
    localparam logic [7:0] O_LU     = 8'b1100_0010;
    localparam logic [7:0] O_FREEZE = 8'b1111_1000;
    localparam logic [7:0] O_BRANCH = 8'b0000_0111;

    always #5 clk = ~clk;

    hazard_scoreboard_ctrl #(.IDX_W(5), .LU_CYCLES(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst),
        .fd_rs1_index(fd_rs1_index), .fd_rs2_index(fd_rs2_index),
        .fd_rs1_used(fd_rs1_used), .fd_rs2_used(fd_rs2_used),
        .de_rd_index(de_rd_index), .de_wb_en(de_wb_en), .de_is_load(de_is_load),
        .em_branch_taken(em_branch_taken), .mem_req_valid(mem_req_valid),
        .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .pc_stall(outs1[7]), .fd_stall(outs1[6]), .de_stall(outs1[5]),
        .em_stall(outs1[4]), .mw_stall(outs1[3]),
        .fd_flush(outs1[2]), .de_flush(outs1[1]), .em_flush(outs1[0]),
        .stall_cycles(sc1), .flush_events(fe1)
    );

    hazard_scoreboard_ctrl #(.IDX_W(5), .LU_CYCLES(3), .CNT_W(16)) dut3 (
        .clk(clk), .rst(rst),
        .fd_rs1_index(fd_rs1_index), .fd_rs2_index(fd_rs2_index),
        .fd_rs1_used(fd_rs1_used), .fd_rs2_used(fd_rs2_used),
        .de_rd_index(de_rd_index), .de_wb_en(de_wb_en), .de_is_load(de_is_load),
        .em_branch_taken(em_branch_taken), .mem_req_valid(mem_req_valid),
        .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .pc_stall(outs3[7]), .fd_stall(outs3[6]), .de_stall(outs3[5]),
        .em_stall(outs3[4]), .mw_stall(outs3[3]),
        .fd_flush(outs3[2]), .de_flush(outs3[1]), .em_flush(outs3[0]),
        .stall_cycles(sc3), .flush_events(fe3)
    );

    hazard_scoreboard_ctrl #(.IDX_W(5), .LU_CYCLES(3), .CNT_W(2)) duts (
        .clk(clk), .rst(rst),
        .fd_rs1_index(fd_rs1_index), .fd_rs2_index(fd_rs2_index),
        .fd_rs1_used(fd_rs1_used), .fd_rs2_used(fd_rs2_used),
        .de_rd_index(de_rd_index), .de_wb_en(de_wb_en), .de_is_load(de_is_load),
        .em_branch_taken(em_branch_taken), .mem_req_valid(mem_req_valid),
        .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .pc_stall(outss[7]), .fd_stall(outss[6]), .de_stall(outss[5]),
        .em_stall(outss[4]), .mw_stall(outss[3]),
        .fd_flush(outss[2]), .de_flush(outss[1]), .em_flush(outss[0]),
        .stall_cycles(scs), .flush_events(fes)
    );

    task automatic clear_inputs();
        fd_rs1_index = 5'd0; fd_rs2_index = 5'd0; de_rd_index = 5'd0;
        fd_rs1_used = 1'b0; fd_rs2_used = 1'b0; de_wb_en = 1'b0; de_is_load = 1'b0;
        em_branch_taken = 1'b0; mem_req_valid = 1'b0; mem_ready = 1'b0; cnt_clr = 1'b0;
    endtask

    // Load writing x5 in execute, decode reads x5 on rs1.
    task automatic set_hazard();
        de_is_load = 1'b1; de_wb_en = 1'b1; de_rd_index = 5'd5;
        fd_rs1_index = 5'd5; fd_rs1_used = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (outs1 !== O_NONE || outs3 !== O_NONE || outss !== O_NONE) begin
            failures++;
            $display("FAIL reset_outs got %b/%b/%b want %b", outs1, outs3, outss, O_NONE);
        end
        checks++;
        if (sc1 !== 16'd0 || fe1 !== 16'd0 || sc3 !== 16'd0 || scs !== 2'd0) begin
            failures++;
            $display("FAIL reset_cnt got sc1=%0d fe1=%0d sc3=%0d scs=%0d want 0", sc1, fe1, sc3, scs);
        end
    endtask

    task automatic test_lu1();
        do_reset();
        set_hazard();
        #1;
        checks++;
        if (outs1 !== O_LU) begin
            failures++;
            $display("FAIL lu1_bubble got %b want %b", outs1, O_LU);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (outs1 !== O_NONE || sc1 !== 16'd1) begin
            failures++;
            $display("FAIL lu1_after got %b sc=%0d want %b sc=1", outs1, sc1, O_NONE);
        end
    endtask

    task automatic test_lu3();
        do_reset();
        set_hazard();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (outs3 !== O_LU) begin
                failures++;
                $display("FAIL lu3_bubble%0d got %b want %b", i, outs3, O_LU);
            end
            tick();
        end
        // Hazard removed: a correctly returned IDLE shows no stall.
        clear_inputs();
        #1;
        checks++;
        if (outs3 !== O_NONE || sc3 !== 16'd3) begin
            failures++;
            $display("FAIL lu3_after got %b sc=%0d want %b sc=3", outs3, sc3, O_NONE);
        end
    endtask

    task automatic test_no_hazard();
        do_reset();
        // Load to x0 read by rs1=x0.
        de_is_load = 1'b1; de_wb_en = 1'b1; de_rd_index = 5'd0;
        fd_rs1_index = 5'd0; fd_rs1_used = 1'b1;
        #1;
        checks++;
        if (outs1 !== O_NONE) begin
            failures++;
            $display("FAIL x0_load got %b want %b", outs1, O_NONE);
        end
        // rs2 matches but is not read.
        clear_inputs();
        de_is_load = 1'b1; de_wb_en = 1'b1; de_rd_index = 5'd9;
        fd_rs2_index = 5'd9; fd_rs2_used = 1'b0;
        #1;
        checks++;
        if (outs1 !== O_NONE) begin
            failures++;
            $display("FAIL rs2_unused got %b want %b", outs1, O_NONE);
        end
        // ALU writer (not a load) matching rs1.
        clear_inputs();
        de_wb_en = 1'b1; de_rd_index = 5'd7; fd_rs1_index = 5'd7; fd_rs1_used = 1'b1;
        #1;
        checks++;
        if (outs1 !== O_NONE) begin
            failures++;
            $display("FAIL alu_writer got %b want %b", outs1, O_NONE);
        end
        // rs2 matches and is read: this one hazards.
        clear_inputs();
        de_is_load = 1'b1; de_wb_en = 1'b1; de_rd_index = 5'd9;
        fd_rs2_index = 5'd9; fd_rs2_used = 1'b1;
        #1;
        checks++;
        if (outs1 !== O_LU) begin
            failures++;
            $display("FAIL rs2_used got %b want %b", outs1, O_LU);
        end
        clear_inputs();
        #1;
    endtask

    task automatic test_freeze();
        do_reset();
        set_hazard();
        tick();
        mem_req_valid = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (outs3 !== O_FREEZE) begin
                failures++;
                $display("FAIL freeze%0d got %b want %b", i, outs3, O_FREEZE);
            end
            tick();
        end
        mem_req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (outs3 !== O_LU) begin
                failures++;
                $display("FAIL post_freeze%0d got %b want %b", i, outs3, O_LU);
            end
            tick();
        end
        clear_inputs();
        #1;
        checks++;
        if (outs3 !== O_NONE || sc3 !== 16'd7) begin
            failures++;
            $display("FAIL freeze_total got %b sc=%0d want %b sc=7", outs3, sc3, O_NONE);
        end
    endtask

    task automatic test_branch();
        do_reset();
        set_hazard();
        em_branch_taken = 1'b1;
        #1;
        checks++;
        if (outs1 !== O_BRANCH || outs3 !== O_BRANCH) begin
            failures++;
            $display("FAIL branch_flush got %b/%b want %b", outs1, outs3, O_BRANCH);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (outs3 !== O_NONE || fe1 !== 16'd1 || fe3 !== 16'd1 || sc1 !== 16'd0) begin
            failures++;
            $display("FAIL branch_after got %b fe1=%0d fe3=%0d sc1=%0d want %b fe=1 sc1=0",
                     outs3, fe1, fe3, sc1, O_NONE);
        end
        // Branch while memory waits: freeze wins, no flush counted.
        em_branch_taken = 1'b1; mem_req_valid = 1'b1; mem_ready = 1'b0;
        #1;
        checks++;
        if (outs1 !== O_FREEZE) begin
            failures++;
            $display("FAIL branch_vs_freeze got %b want %b", outs1, O_FREEZE);
        end
        tick();
        checks++;
        if (fe1 !== 16'd1) begin
            failures++;
            $display("FAIL freeze_holds_fe got %0d want 1", fe1);
        end
        // Branch in the middle of a bubble run returns to IDLE.
        clear_inputs();
        set_hazard();
        tick();
        clear_inputs();
        em_branch_taken = 1'b1;
        tick();
        em_branch_taken = 1'b0;
        #1;
        checks++;
        if (outs3 !== O_NONE) begin
            failures++;
            $display("FAIL branch_mid_lu got %b want %b", outs3, O_NONE);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        set_hazard();
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        checks++;
        if (scs !== 2'd3) begin
            failures++;
            $display("FAIL sat_cnt got %0d want 3", scs);
        end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        checks++;
        if (scs !== 2'd0) begin
            failures++;
            $display("FAIL cnt_clr got %0d want 0", scs);
        end
        // Now IDLE with hazard held: enter LU_STALL, then reset mid-run.
        tick();
        #1;
        checks++;
        if (outss !== O_LU || scs !== 2'd1) begin
            failures++;
            $display("FAIL pre_rst got %b sc=%0d want %b sc=1", outss, scs, O_LU);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_inputs();
        #1;
        checks++;
        if (outss !== O_NONE || scs !== 2'd0) begin
            failures++;
            $display("FAIL rst_mid_lu got %b sc=%0d want %b sc=0", outss, scs, O_NONE);
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_lu1();
        test_lu3();
        test_no_hazard();
        test_freeze();
        test_branch();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
